// File: rtl/gfsk_tx_sequencer.sv
// GFSK packet sequencer: preamble, sync word, payload and tail symbols with NCO phase increments.
// Optional CRC-8 field (poly 0x07) between payload and tail when GFSK_TX_CRC_EN is defined.
`timescale 1ns/1ps
module gfsk_tx_sequencer #(
    parameter int          SYM_DIV        = 100,
    parameter int          FWC_MARK       = 1310,
    parameter int          FWC_SPACE      = 2620,
    parameter int          PREAMBLE_BYTES = 4,
    parameter logic [15:0] SYNC_WORD      = 16'h2DD4,
    parameter int          TAIL_SYMS      = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tx_start,
    input  logic [7:0]  tx_len,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        mod_bit,
    output logic [15:0] phi_inc,
    output logic        nco_en,
    output logic        sym_strobe,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_PAYLOAD,
`ifdef GFSK_TX_CRC_EN
        S_CRC,
`endif
        S_TAIL
    } state_t;

    localparam logic [15:0] SYM_LAST  = 16'(SYM_DIV - 1);
    localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_BYTES * 8 - 1);
    localparam logic [7:0]  TAIL_LAST = 8'(TAIL_SYMS - 1);
    localparam logic [15:0] PHI_MARK  = 16'(FWC_MARK);
    localparam logic [15:0] PHI_SPACE = 16'(FWC_SPACE);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  byte_reg, byte_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  sent_reg, sent_next;
    logic [7:0]  crc_reg, crc_next;
    logic        mod_bit_reg, phi_sel_next;
    logic [15:0] phi_inc_reg;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        load_bit, field_end;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    assign busy       = (state_reg != S_IDLE);
    assign nco_en     = busy;
    assign sym_strobe = busy && (cnt_reg == SYM_LAST);
    assign mod_bit    = mod_bit_reg;
    assign phi_inc    = phi_inc_reg;
    assign done       = done_reg;
    assign err        = err_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        byte_next    = byte_reg;
        len_next     = len_reg;
        sent_next    = sent_reg;
        crc_next     = crc_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        s_ready      = 1'b0;
        load_bit     = 1'b0;
        field_end    = 1'b0;
        phi_sel_next = 1'b0;

        if (state_reg == S_IDLE) begin
            cnt_next = 16'd0;
            // The done cycle still reads as IDLE but must not launch a new packet
            if (tx_start && !done_reg) begin
                state_next = S_PREAMBLE;
                idx_next   = 8'd0;
                len_next   = tx_len;
                sent_next  = 8'd0;
                crc_next   = 8'd0;
                load_bit   = 1'b1;
            end
        end else begin
            cnt_next = sym_strobe ? 16'd0 : 16'(cnt_reg + 16'd1);
            if (sym_strobe) begin
                load_bit = 1'b1;
                idx_next = 8'(idx_reg + 8'd1);
                case (state_reg)
                    S_PREAMBLE: if (idx_reg == PRE_LAST) begin
                        state_next = S_SYNC;
                        idx_next   = 8'd0;
                    end
                    S_SYNC:    field_end = (idx_reg == 8'd15);
                    S_PAYLOAD: field_end = (idx_reg == 8'd7);
`ifdef GFSK_TX_CRC_EN
                    S_CRC: if (idx_reg == 8'd7) begin
                        state_next = S_TAIL;
                        idx_next   = 8'd0;
                    end
`endif
                    S_TAIL: if (idx_reg == TAIL_LAST) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                    default: ;
                endcase
                // Sync or byte boundary: fetch the next payload byte or move on
                if (field_end) begin
                    idx_next = 8'd0;
                    if (sent_reg != len_reg) begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            state_next = S_PAYLOAD;
                            byte_next  = s_data;
                            sent_next  = 8'(sent_reg + 8'd1);
                            crc_next   = crc8_byte(crc_reg, s_data);
                        end else begin
                            state_next = S_IDLE;
                            err_next   = 1'b1;
                        end
                    end else begin
`ifdef GFSK_TX_CRC_EN
                        state_next = S_CRC;
`else
                        state_next = S_TAIL;
`endif
                    end
                end
            end
        end

        case (state_next)
            S_PREAMBLE: phi_sel_next = idx_next[0];
            S_SYNC:     phi_sel_next = SYNC_WORD[4'd15 - idx_next[3:0]];
            S_PAYLOAD:  phi_sel_next = byte_next[3'd7 - idx_next[2:0]];
`ifdef GFSK_TX_CRC_EN
            S_CRC:      phi_sel_next = crc_next[3'd7 - idx_next[2:0]];
`endif
            default:    phi_sel_next = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 16'd0;
            idx_reg     <= 8'd0;
            byte_reg    <= 8'd0;
            len_reg     <= 8'd0;
            sent_reg    <= 8'd0;
            crc_reg     <= 8'd0;
            mod_bit_reg <= 1'b0;
            phi_inc_reg <= PHI_SPACE;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            byte_reg  <= byte_next;
            len_reg   <= len_next;
            sent_reg  <= sent_next;
            crc_reg   <= crc_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (load_bit) begin
                mod_bit_reg <= phi_sel_next;
                phi_inc_reg <= phi_sel_next ? PHI_MARK : PHI_SPACE;
            end
        end
    end

endmodule

// File: tb/tb_gfsk_tx_sequencer.sv
// Directed bench for gfsk_tx_sequencer (SYM_DIV=4, one preamble byte, two tail symbols).
`timescale 1ns/1ps
module tb_gfsk_tx_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        tx_start;
    logic [7:0]  tx_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mod_bit;
    logic [15:0] phi_inc;
    logic        nco_en;
    logic        sym_strobe;
    logic        busy;
    logic        done;
    logic        err;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0   = 0;
    int nacc = 0;

    gfsk_tx_sequencer #(
        .SYM_DIV(4), .FWC_MARK(1310), .FWC_SPACE(2620),
        .PREAMBLE_BYTES(1), .SYNC_WORD(16'h2DD4), .TAIL_SYMS(2)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_start(tx_start), .tx_len(tx_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .mod_bit(mod_bit),
        .phi_inc(phi_inc), .nco_en(nco_en), .sym_strobe(sym_strobe), .busy(busy),
        .done(done), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (s_ready && s_valid) nacc <= nacc + 1;
    end

    function automatic logic [7:0] ref_crc8(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered on the first cycle of symbol k; returns on the first cycle of symbol k+1.
    task automatic check_sym(input logic b, input logic rdy, input logic pulse);
        chk("mod_bit", mod_bit, b);
        chk("phi_inc", phi_inc, b ? 1310 : 2620);
        chk("busy", busy, 1);
        chk("nco_en", nco_en, 1);
        chk("strobe_lo", sym_strobe, 0);
        chk("s_ready_lo", s_ready, 0);
        if (pulse) tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("strobe_hi", sym_strobe, 1);
        chk("s_ready", s_ready, rdy);
        chk("mod_bit_hold", mod_bit, b);
        @(negedge sys_clk);
    endtask

    task automatic run_syms(input logic [63:0] bits, input int nsym, input int first,
                            input int last, input int len, input int pulse_at);
        for (int k = first; k <= last; k++)
            check_sym(bits[nsym - 1 - k], (k >= 23) && (k < 23 + 8 * len) && ((k - 23) % 8 == 0),
                      k == pulse_at);
    endtask

    task automatic begin_pkt(input logic [7:0] len);
        tx_start = 1'b1;
        tx_len   = len;
        @(negedge sys_clk);
        tx_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic check_done(input int nsym);
        chk("done", done, 1);
        chk("done_cycle", cyc - t0, nsym * 4);
        chk("busy_end", busy, 0);
        chk("nco_en_end", nco_en, 0);
        chk("err_end", err, 0);
        chk("mod_bit_idle", mod_bit, 0);
        chk("phi_idle", phi_inc, 2620);
    endtask

    task automatic check_reset_values();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mod_bit", mod_bit, 0);
        chk("rst_phi_inc", phi_inc, 2620);
        chk("rst_nco_en", nco_en, 0);
        chk("rst_strobe", sym_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    logic [63:0] bits;
    int          nsym;

    initial begin
        sys_rst = 1'b1; tx_start = 1'b0; tx_len = 8'd0;
        s_data = 8'hA5; s_valid = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_reset_values();

        // Packet 1: one payload byte 0xA5, start accepted on the first edge after reset release
        bits = 64'({8'b01010101, 16'b0010110111010100, 8'hA5});
        nsym = 32;
`ifdef GFSK_TX_CRC_EN
        bits = (bits << 8) | 64'(ref_crc8(8'hA5));
        nsym = nsym + 8;
`endif
        bits = bits << 2;
        nsym = nsym + 2;
        sys_rst = 1'b0;
        begin_pkt(8'd1);
        run_syms(bits, nsym, 0, nsym - 1, 1, -1);
        check_done(nsym);
        chk("bytes_accepted", nacc, 1);
        $display("packet len=1 byte=a5 symbols=%0d cycles=%0d", nsym, cyc - t0);
        // tx_start presented in the done cycle must be ignored
        tx_start = 1'b1; tx_len = 8'd0;
        @(negedge sys_clk);
        tx_start = 1'b0;
        chk("done_pulse_width", done, 0);
        chk("start_in_done_ignored", busy, 0);
        $display("tx_start during done cycle: busy=%0b", busy);

        // Packet 2: reset asserted mid-SYNC, then a zero-length packet with a redundant tx_start
        bits = 64'({8'b01010101, 16'b0010110111010100, 2'b00});
        nsym = 26;
        @(negedge sys_clk);
        begin_pkt(8'd0);
        run_syms(bits, nsym, 0, 11, 0, -1);
        #2 sys_rst = 1'b1;
        #1 check_reset_values();
        $display("reset asserted mid-sync: busy=%0b nco_en=%0b", busy, nco_en);
        tx_start = 1'b1; tx_len = 8'd0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        tx_start = 1'b0;
        t0 = cyc;
        tx_len = 8'd5;
        run_syms(bits, nsym, 0, nsym - 1, 0, 3);
        check_done(nsym);
        $display("packet len=0 with repeated tx_start: symbols=%0d cycles=%0d", nsym, cyc - t0);

        // Packet 3: two bytes requested, second byte not offered -> underrun
        @(negedge sys_clk);
        @(negedge sys_clk);
        nacc = 0;
        s_valid = 1'b1;
        bits = 64'({8'b01010101, 16'b0010110111010100, 8'hA5});
        nsym = 32;
        begin_pkt(8'd2);
        run_syms(bits, nsym, 0, 23, 2, -1);
        s_valid = 1'b0;
        run_syms(bits, nsym, 24, 31, 2, -1);
        chk("err", err, 1);
        chk("busy_after_err", busy, 0);
        chk("nco_en_after_err", nco_en, 0);
        chk("done_on_err", done, 0);
        chk("mod_bit_after_err", mod_bit, 0);
        @(negedge sys_clk);
        chk("err_pulse_width", err, 0);
        chk("done_after_err", done, 0);
        chk("bytes_before_underrun", nacc, 1);
        $display("packet len=2 underrun: err observed, busy=%0b", busy);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
